// File: rtl/rf_stage.sv
// rf_stage: register-fetch/decode stage of the Beta pipeline.
//
// Latches the fetched PC/IR, decodes the opcode, reads the 32x32 register
// file with bypassing from the ALU/MEM/WB stages, and resolves JMP/BEQ/BNE
// and illegal opcodes for fetch. It also generates the pipeline stall.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   : full ALU/MEM/WB bypass, stall only on load-use
//   undefined : WB write-through only, stall on any in-flight ALU/MEM writer
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   pc_next, ir_next              PC+4 and instruction from fetch
//   irq                           interrupt request (IR source select only)
//   wb_we, wb_rc, wb_data         register-file write port from WB
//   alu_we, alu_rc, alu_res       in-flight writer in ALU stage
//   mem_we, mem_rc, mem_res       in-flight writer in MEM stage
//   alu_is_ld                     ALU-stage instruction is LD/LDR
//   stall                         holds fetch and this stage
//   zr                            bypassed Ra == 0
//   ir_src_rf                     IR source select for fetch
//   ill_op, op_jmp, op_beq, op_bne decode results
//   br_addr, j_addr               branch / jump targets
//   pc_alu_next, ir_alu_next      ALU stage register inputs
//   a_next, b_next, d_next        Ra, Rb-or-literal, store data (Rc)

`ifndef INST_NOP
`define INST_NOP 32'h83FF_F800
`endif
`ifndef PC_RESET_ADDR
`define PC_RESET_ADDR 32'h0000_0000
`endif
`ifndef IR_SRC_DATA
`define IR_SRC_DATA 2'd0
`endif
`ifndef IR_SRC_NOP
`define IR_SRC_NOP 2'd1
`endif
`ifndef IR_SRC_EXCEPT
`define IR_SRC_EXCEPT 2'd2
`endif

module rf_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic [31:0] ir_next,
  input  logic        irq,
  input  logic        wb_we,
  input  logic [4:0]  wb_rc,
  input  logic [31:0] wb_data,
  input  logic        alu_we,
  input  logic        mem_we,
  input  logic [4:0]  alu_rc,
  input  logic [4:0]  mem_rc,
  input  logic [31:0] alu_res,
  input  logic [31:0] mem_res,
  input  logic        alu_is_ld,
  output logic        stall,
  output logic        zr,
  output logic [1:0]  ir_src_rf,
  output logic        ill_op,
  output logic        op_jmp,
  output logic        op_beq,
  output logic        op_bne,
  output logic [31:0] br_addr,
  output logic [31:0] j_addr,
  output logic [31:0] pc_alu_next,
  output logic [31:0] ir_alu_next,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] d_next
);

  logic [31:0] pc_rf;
  logic [31:0] ir_rf;
  logic [31:0] regs [0:31];

  logic [5:0]  opcode;
  logic [4:0]  rc, ra, rb, rb2;
  logic [15:0] lit;
  logic [31:0] lit_sext;
  logic        legal, is_ld, is_st, is_ldr, use_lit, use_ra, use_p2;
  logic [31:0] ra_val, p2_val, rc_val;

  // Pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_rf <= `PC_RESET_ADDR;
      ir_rf <= `INST_NOP;
    end else if (!stall) begin
      pc_rf <= pc_next;
      ir_rf <= ir_next;
    end
  end

  // Register array, intentionally not reset; R31 is never stored
  always_ff @(posedge clk) begin
    if (wb_we && wb_rc != 5'd31)
      regs[wb_rc] <= wb_data;
  end

  assign opcode   = ir_rf[31:26];
  assign rc       = ir_rf[25:21];
  assign ra       = ir_rf[20:16];
  assign rb       = ir_rf[15:11];
  assign lit      = ir_rf[15:0];
  assign lit_sext = {{16{lit[15]}}, lit};

  assign is_ld  = (opcode == 6'h18);
  assign is_st  = (opcode == 6'h19);
  assign is_ldr = (opcode == 6'h1F);

  // 0x20-0x3F are legal except every xxx111 slot
  always_comb begin
    case (opcode)
      6'h18, 6'h19, 6'h1B, 6'h1C, 6'h1D, 6'h1F: legal = 1'b1;
      default: legal = opcode[5] && (opcode[2:0] != 3'b111);
    endcase
  end

  assign use_lit = (opcode >= 6'h30) || is_ld || is_st || is_ldr;
  assign rb2     = is_st ? rc : rb;

  // Registers genuinely consumed: LDR has no Ra; only register-form ALU ops
  // and ST use the second port. Used to avoid spurious interlocks.
  assign use_ra = legal && !is_ldr;
  assign use_p2 = legal && (is_st || (opcode[5:4] == 2'b10));

  // Later assignments override earlier ones, giving ALU > MEM > WB > array
  function automatic logic [31:0] rd_port(input logic [4:0] r,
                                          input logic [31:0] arr);
    logic [31:0] v;
    v = arr;
    if (wb_we && wb_rc == r) v = wb_data;
`ifdef RF_BYPASS_EN
    if (mem_we && mem_rc == r) v = mem_res;
    if (alu_we && alu_rc == r) v = alu_res;
`endif
    if (r == 5'd31) v = '0;
    return v;
  endfunction

  function automatic logic hazard(input logic [4:0] r);
`ifdef RF_BYPASS_EN
    return (r != 5'd31) && alu_is_ld && alu_we && (alu_rc == r);
`else
    return (r != 5'd31) && ((alu_we && alu_rc == r) || (mem_we && mem_rc == r));
`endif
  endfunction

`ifndef RF_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{alu_res, mem_res, alu_is_ld};
`endif

  always_comb begin
    ra_val = rd_port(ra, regs[ra]);
    p2_val = rd_port(rb2, regs[rb2]);
    rc_val = rd_port(rc, regs[rc]);
  end

  always_comb begin
    stall = (use_ra && hazard(ra)) || (use_p2 && hazard(rb2));
  end

  assign a_next      = ra_val;
  assign b_next      = use_lit ? lit_sext : p2_val;
  assign d_next      = rc_val;
  assign zr          = (a_next == 32'd0);
  assign j_addr      = a_next & ~32'h3;
  assign br_addr     = pc_rf + {lit_sext[29:0], 2'b00};
  assign pc_alu_next = pc_rf;

  always_comb begin
    ill_op      = 1'b0;
    op_jmp      = 1'b0;
    op_beq      = 1'b0;
    op_bne      = 1'b0;
    ir_alu_next = ir_rf;
    if (stall) begin
      ir_alu_next = `INST_NOP;
    end else if (!legal) begin
      ill_op      = 1'b1;
      ir_alu_next = `INST_NOP;
    end else begin
      op_jmp = (opcode == 6'h1B);
      op_beq = (opcode == 6'h1C);
      op_bne = (opcode == 6'h1D);
    end
  end

  always_comb begin
    if (irq || ill_op)
      ir_src_rf = `IR_SRC_EXCEPT;
    else if (op_jmp || (op_beq && zr) || (op_bne && !zr))
      ir_src_rf = `IR_SRC_NOP;
    else
      ir_src_rf = `IR_SRC_DATA;
  end

endmodule
